// File: rtl/mips_pkg.sv
// Shared encodings for the memory-write checker: FSM states and compare modes.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  typedef enum logic {
    MODE_ANY     = 1'b0,
    MODE_ORDERED = 1'b1
  } mode_t;

endpackage

// File: rtl/check_entry_cmp.sv
// One check-table entry: enable/address/data register plus address-hit and
// full-match detection against the current bus write.
module check_entry_cmp #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              wr,
  input  logic [DATA_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              en,
  output logic              addr_hit,
  output logic              match
);

  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] data;

  always_ff @(posedge clk) begin
    if (reset) begin
      en   <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      en   <= load_en;
      addr <= load_addr;
      data <= load_data;
    end
  end

  assign addr_hit = en && wr && (dataadr == addr);
  assign match    = addr_hit && (writedata == data);

endmodule

// File: rtl/mem_write_checker.sv
// Watches a memory write bus for configured address/data writes (any-of or
// in-order) and reports pass, strict-data fail, or timeout.
module mem_write_checker
  import mips_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int NUM_CHECKS = 4,
  parameter int CNT_W      = 10,
  localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        memwrite,
  input  logic [DATA_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [DATA_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              mode,
  input  logic              strict,
  input  logic [CNT_W-1:0]  timeout_cycles,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [IDX_W-1:0]  match_id,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  write_count
);

  state_t                  state, state_n;
  logic [IDX_W-1:0]        ptr, ptr_n, mid_n;
  logic [CNT_W-1:0]        cyc_n, wcnt_n;
  logic                    wr;
  logic [NUM_CHECKS-1:0]   en, addr_hit, match;
  logic [IDX_W-1:0]        first_en, next_en, match_idx, miss_idx;
  logic                    has_next, any_match, any_miss;
  logic                    pass_hit, fail_hit, tmo_hit;

  assign wr = |memwrite;

  for (genvar g = 0; g < NUM_CHECKS; g++) begin : g_entry
    check_entry_cmp #(.DATA_W(DATA_W)) u_entry (
      .clk       (clk),
      .reset     (reset),
      .load      (cfg_we && (cfg_idx == IDX_W'(g))),
      .load_en   (cfg_en),
      .load_addr (cfg_addr),
      .load_data (cfg_data),
      .wr        (wr),
      .dataadr   (dataadr),
      .writedata (writedata),
      .en        (en[g]),
      .addr_hit  (addr_hit[g]),
      .match     (match[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cycle_count <= '0;
      write_count <= '0;
      match_id    <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cycle_count <= cyc_n;
      write_count <= wcnt_n;
      match_id    <= mid_n;
      done        <= state_n inside {ST_PASS, ST_FAIL, ST_TIMEOUT};
      pass        <= (state_n == ST_PASS);
      fail        <= (state_n == ST_FAIL);
      timeout     <= (state_n == ST_TIMEOUT);
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cyc_n     = cycle_count;
    wcnt_n    = write_count;
    mid_n     = match_id;
    first_en  = '0;
    next_en   = '0;
    has_next  = 1'b0;
    any_match = 1'b0;
    match_idx = '0;
    any_miss  = 1'b0;
    miss_idx  = '0;
    pass_hit  = 1'b0;
    fail_hit  = 1'b0;
    tmo_hit   = 1'b0;

    // Descending scan so the last assignment leaves the lowest qualifying index.
    for (int unsigned i = NUM_CHECKS; i > 0; i--) begin
      if (en[i-1]) first_en = IDX_W'(i-1);
      if (en[i-1] && (IDX_W'(i-1) > ptr)) begin
        next_en  = IDX_W'(i-1);
        has_next = 1'b1;
      end
      if (match[i-1]) begin
        any_match = 1'b1;
        match_idx = IDX_W'(i-1);
      end
      if (addr_hit[i-1] && !match[i-1]) begin
        any_miss = 1'b1;
        miss_idx = IDX_W'(i-1);
      end
    end

    if (start) begin
      state_n = ST_RUN;
      ptr_n   = first_en;
      cyc_n   = '0;
      wcnt_n  = '0;
      mid_n   = '0;
    end else if (state == ST_RUN) begin
      tmo_hit = (timeout_cycles != '0) && (cycle_count == timeout_cycles);
      if (cycle_count != '1) cyc_n = cycle_count + CNT_W'(1);
      if (wr && (write_count != '1)) wcnt_n = write_count + CNT_W'(1);

      if (mode == MODE_ORDERED) begin
        if (match[ptr]) begin
          mid_n = ptr;
          if (has_next) ptr_n = next_en;
          else pass_hit = 1'b1;
        end else if (strict && addr_hit[ptr]) begin
          fail_hit = 1'b1;
          mid_n    = ptr;
        end
      end else begin
        if (any_match) begin
          pass_hit = 1'b1;
          mid_n    = match_idx;
        end else if (strict && any_miss) begin
          fail_hit = 1'b1;
          mid_n    = miss_idx;
        end
      end

      if (pass_hit)      state_n = ST_PASS;
      else if (fail_hit) state_n = ST_FAIL;
      else if (tmo_hit)  state_n = ST_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Randomized scoreboard bench for mem_write_checker with a behavioural model.
module tb_mem_write_checker;

  localparam int DW   = 64;
  localparam int NC   = 4;
  localparam int CW   = 10;
  localparam int IW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;
  localparam int M_FAIL = 3;
  localparam int M_TMO  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    memwrite;
  logic [DW-1:0] dataadr, writedata;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic          cfg_en;
  logic [DW-1:0] cfg_addr, cfg_data;
  logic          start, mode, strict;
  logic [CW-1:0] timeout_cycles;
  logic          done, pass, fail, timeout;
  logic [IW-1:0] match_id;
  logic [CW-1:0] cycle_count, write_count;

  mem_write_checker #(.DATA_W(DW), .NUM_CHECKS(NC), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .memwrite       (memwrite),
    .dataadr        (dataadr),
    .writedata      (writedata),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_en         (cfg_en),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .start          (start),
    .mode           (mode),
    .strict         (strict),
    .timeout_cycles (timeout_cycles),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .timeout        (timeout),
    .match_id       (match_id),
    .cycle_count    (cycle_count),
    .write_count    (write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          done, pass, fail, tmo;
    int unsigned mid, cc, wc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  bit            m_en[NC];
  logic [DW-1:0] m_addr[NC], m_data[NC];
  int            m_st = M_IDLE;
  int            m_ptr = 0;
  int unsigned   m_cc = 0, m_wc = 0, m_mid = 0;

  task automatic model_step();
    exp_t        e;
    bit          wr, tmo_hit, pass_hit, fail_hit;
    int unsigned hit_id;
    wr = (memwrite != 2'b00);
    if (reset) begin
      for (int i = 0; i < NC; i++) m_en[i] = 1'b0;
      m_st = M_IDLE; m_ptr = 0; m_cc = 0; m_wc = 0; m_mid = 0;
    end else begin
      if (start) begin
        m_st = M_RUN; m_cc = 0; m_wc = 0; m_mid = 0; m_ptr = 0;
        for (int i = NC - 1; i >= 0; i--) if (m_en[i]) m_ptr = i;
      end else if (m_st == M_RUN) begin
        tmo_hit  = (timeout_cycles != 0) && (m_cc == timeout_cycles);
        if (m_cc < CMAX) m_cc++;
        if (wr && m_wc < CMAX) m_wc++;
        pass_hit = 1'b0;
        fail_hit = 1'b0;
        hit_id   = m_mid;
        if (wr && !mode) begin
          for (int i = NC - 1; i >= 0; i--)
            if (m_en[i] && dataadr == m_addr[i] && writedata == m_data[i]) begin
              pass_hit = 1'b1; hit_id = i;
            end
          if (!pass_hit && strict)
            for (int i = NC - 1; i >= 0; i--)
              if (m_en[i] && dataadr == m_addr[i]) begin
                fail_hit = 1'b1; hit_id = i;
              end
        end else if (wr && m_en[m_ptr] && dataadr == m_addr[m_ptr]) begin
          if (writedata == m_data[m_ptr]) begin
            int nxt;
            nxt = -1;
            for (int i = NC - 1; i > m_ptr; i--) if (m_en[i]) nxt = i;
            hit_id = m_ptr;
            if (nxt < 0) pass_hit = 1'b1;
            else m_ptr = nxt;
          end else if (strict) begin
            fail_hit = 1'b1; hit_id = m_ptr;
          end
        end
        m_mid = hit_id;
        m_st  = pass_hit ? M_PASS : fail_hit ? M_FAIL : tmo_hit ? M_TMO : M_RUN;
      end
      if (cfg_we) begin
        m_en[cfg_idx]   = cfg_en;
        m_addr[cfg_idx] = cfg_addr;
        m_data[cfg_idx] = cfg_data;
      end
    end
    e.done = (m_st >= M_PASS);
    e.pass = (m_st == M_PASS);
    e.fail = (m_st == M_FAIL);
    e.tmo  = (m_st == M_TMO);
    e.mid  = m_mid;
    e.cc   = m_cc;
    e.wc   = m_wc;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (done !== mon_e.done || pass !== mon_e.pass || fail !== mon_e.fail ||
          timeout !== mon_e.tmo || match_id !== IW'(mon_e.mid) ||
          cycle_count !== CW'(mon_e.cc) || write_count !== CW'(mon_e.wc)) begin
        miscompares++;
        $display("FAIL out@%0t: got d%0b p%0b f%0b t%0b id%0d cc%0d wc%0d, want d%0b p%0b f%0b t%0b id%0d cc%0d wc%0d",
                 $time, done, pass, fail, timeout, match_id, cycle_count, write_count,
                 mon_e.done, mon_e.pass, mon_e.fail, mon_e.tmo, mon_e.mid, mon_e.cc, mon_e.wc);
      end
    end
  end

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_in();
    reset = 1'b0; start = 1'b0; cfg_we = 1'b0; memwrite = 2'b00;
  endtask

  task automatic do_reset();
    clear_in(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic cfg(input int idx, input bit e, input logic [DW-1:0] a, input logic [DW-1:0] d);
    clear_in();
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_en = e; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic arm(input bit md, input bit st, input int to);
    clear_in();
    mode = md; strict = st; timeout_cycles = CW'(to); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic bus_wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
    clear_in();
    memwrite = 2'($urandom_range(1, 3)); dataadr = a; writedata = d;
    tick();
    memwrite = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      clear_in();
      tick();
    end
  endtask

  function automatic logic [DW-1:0] pick_addr();
    logic [DW-1:0] v;
    case ($urandom_range(0, 3))
      0: v = 64'd80;
      1: v = 64'd84;
      2: v = 64'd128;
      default: v = 64'h8000_0000_0000_0054;
    endcase
    return v;
  endfunction

  function automatic logic [DW-1:0] pick_data();
    logic [DW-1:0] v;
    case ($urandom_range(0, 3))
      0: v = 64'd1;
      1: v = 64'd6;
      2: v = 64'd7;
      default: v = 64'h8000_0000_0000_0007;
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    clear_in();
    dataadr = '0; writedata = '0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_addr = '0; cfg_data = '0; mode = 1'b0; strict = 1'b0; timeout_cycles = '0;
    @(negedge clk);
    do_reset();
    check("reset_done", done, 0);
    check("reset_cc", cycle_count, 0);

    // ANY mode, hit on second entry
    cfg(0, 1, 84, 7); cfg(1, 1, 128, 7); cfg(2, 1, 80, 1);
    arm(0, 0, 0);
    idle(5);
    bus_wr(128, 7);
    check("any_pass", pass, 1);
    check("any_id", match_id, 1);
    check("any_wc", write_count, 1);

    // ORDERED: out-of-order write is ignored
    do_reset();
    cfg(0, 1, 80, 1); cfg(1, 1, 84, 7);
    arm(1, 0, 0);
    bus_wr(84, 7);
    bus_wr(80, 1);
    check("ord_not_yet", done, 0);
    bus_wr(84, 7);
    check("ord_pass", pass, 1);
    check("ord_id", match_id, 1);

    // Strict data mismatch
    do_reset();
    cfg(0, 1, 84, 7);
    arm(0, 1, 0);
    bus_wr(84, 6);
    check("strict_fail", fail, 1);
    check("strict_id", match_id, 0);
    arm(0, 0, 0);
    bus_wr(84, 6);
    idle(2);
    check("lax_running", done, 0);

    // Timeout and hold
    arm(0, 0, 200);
    for (int k = 0; k < 260 && !timeout; k++) idle(1);
    check("tmo_flag", timeout, 1);
    idle(3);
    check("tmo_hold", timeout, 1);

    // Match and timeout decided in the same cycle
    arm(0, 0, 6);
    idle(6);
    bus_wr(84, 7);
    check("pri_pass", pass, 1);
    check("pri_tmo", timeout, 0);

    // Reset mid-run disables the table
    arm(0, 0, 0);
    idle(2);
    do_reset();
    check("rst_done", done, 0);
    arm(0, 1, 0);
    bus_wr(84, 7);
    idle(2);
    check("rst_tbl_off", done, 0);

    // Counter saturation with the timeout disabled
    cfg(0, 1, 84, 7);
    arm(0, 0, 0);
    idle(1030);
    check("cc_sat", cycle_count, CMAX);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      clear_in();
      reset = ($urandom_range(0, 999) < 5);
      start = ($urandom_range(0, 39) == 0);
      if (start) begin
        mode = 1'($urandom);
        strict = 1'($urandom);
        timeout_cycles = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(3, 80));
      end
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_idx = IW'($urandom);
      cfg_en = ($urandom_range(0, 3) != 0);
      cfg_addr = pick_addr();
      cfg_data = pick_data();
      memwrite = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
      dataadr = pick_addr();
      writedata = pick_data();
      tick();
    end

    clear_in();
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected outputs left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
